dap_swj_sequence: RTL and testbench



---
 rtl/dap_swj_sequence_pkg.sv | 24 ++
 rtl/dap_swj_sequence_if.sv | 40 ++++
 rtl/dap_swj_sequence_swj_clk_gen.sv | 37 +++
 rtl/dap_swj_sequence.sv | 199 +++++++++++++++++++
 tb/tb_dap_swj_sequence.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dap_swj_sequence_pkg.sv
// dap_swj_sequence_pkg
// Shared definitions for the DAP_SWJ_Sequence command worker:
//   - CMSIS-DAP command id and status bytes written into the response
//   - length of the response packet
//   - state encoding of the sequence FSM
package dap_swj_sequence_pkg;

  localparam logic [7:0] DAP_CMD_SWJ_SEQUENCE = 8'h12;
  localparam logic [7:0] DAP_OK               = 8'h00;
  localparam logic [7:0] DAP_ERROR            = 8'hFF;
  localparam logic [9:0] SWJ_SEQ_RESP_LEN     = 10'd2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_COUNT = 3'd1,
    GET_DATA  = 3'd2,
    CLK_LOW   = 3'd3,
    CLK_HIGH  = 3'd4,
    RESP0     = 3'd5,
    RESP1     = 3'd6,
    DONE      = 3'd7
  } swj_seq_state_e;

endpackage

// File: rtl/dap_swj_sequence_if.sv
// dap_swj_sequence_if
// Bundles the command-worker side of dap_swj_sequence: dispatcher
// start/done, the clock divider from the SWJ register block, the shared
// dap_in payload byte stream and the response RAM write port.
//   master : dispatcher / stream source / RAM owner
//   slave  : the sequence worker
// Signals:
//   start, done                    command handshake (one-cycle pulses)
//   clk_div [DIV_WIDTH]            SWCLK half-period minus one
//   dap_in_tvalid/tready/tdata     payload byte stream
//   ram_write_addr/data/en         response RAM write port
//   packet_len                     response length
interface dap_swj_sequence_if #(
  parameter int DIV_WIDTH = 16
) ();

  logic                 start;
  logic                 done;
  logic [DIV_WIDTH-1:0] clk_div;
  logic                 dap_in_tvalid;
  logic                 dap_in_tready;
  logic [7:0]           dap_in_tdata;
  logic [9:0]           ram_write_addr;
  logic [7:0]           ram_write_data;
  logic                 ram_write_en;
  logic [9:0]           packet_len;

  modport master (
    output start, clk_div, dap_in_tvalid, dap_in_tdata,
    input  done, dap_in_tready, ram_write_addr, ram_write_data,
           ram_write_en, packet_len
  );

  modport slave (
    input  start, clk_div, dap_in_tvalid, dap_in_tdata,
    output done, dap_in_tready, ram_write_addr, ram_write_data,
           ram_write_en, packet_len
  );

endinterface

// File: rtl/dap_swj_sequence_swj_clk_gen.sv
// swj_clk_gen
// Half-period timer for SWCLK/TCK generation, shared with the JTAG
// sequence worker. While run is high the counter counts down from
// half_period; tick pulses in the last cycle of each half period
// (half_period+1 cycles apart) and the counter reloads itself.
// While run is low the counter stays preloaded, so the first half
// period after run rises is full length.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   run                  1 = a clock phase is in progress
//   half_period          half period minus one, in clk cycles
//   tick                 end of the current half period
module swj_clk_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] half_period,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;

  assign tick = run && (count == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (!run || tick) begin
      count <= half_period;
    end else begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/dap_swj_sequence.sv
// dap_swj_sequence
// CMSIS-DAP DAP_SWJ_Sequence (0x12) worker. After the dispatcher pulses
// start, reads the bit count and the payload bytes from dap_in, shifts
// the bits LSB-first onto SWDIO/TMS with a generated SWCLK/TCK, writes
// the response {0x12, status} into response RAM and pulses done.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   bus (slave)        start/done, clk_div, dap_in stream, RAM port,
//                      packet_len (see dap_swj_sequence_if)
//   SWCLK_TCK_O        SWCLK/TCK, idles high
//   SWDIO_TMS_O        SWDIO/TMS data, holds the last bit shifted
//   SWDIO_TMS_T        SWDIO/TMS tristate, 1 = released
//   abort              only with DAP_SWJ_SEQ_ABORT_EN: stop clocking
//                      after the current high phase, drain the rest of
//                      the payload and answer DAP_ERROR
// Optional feature macro: DAP_SWJ_SEQ_ABORT_EN
module dap_swj_sequence
  import dap_swj_sequence_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic              clk,
  input  logic              resetn,
  dap_swj_sequence_if.slave bus,
  output logic              SWCLK_TCK_O,
  output logic              SWDIO_TMS_O,
  output logic              SWDIO_TMS_T
`ifdef DAP_SWJ_SEQ_ABORT_EN
  ,
  input  logic              abort
`endif
);

  swj_seq_state_e       state;
  logic [DIV_WIDTH-1:0] clk_div_q;
  logic [8:0]           remaining;
  logic [7:0]           shift;
  logic [2:0]           bit_idx;
  logic                 aborted;
  logic                 abort_hit;
  logic                 run;
  logic                 tick;
  logic                 handshake;
  logic [8:0]           bits_left;
  logic [8:0]           skip_bits;

`ifdef DAP_SWJ_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign run       = (state == CLK_LOW) || (state == CLK_HIGH);
  assign handshake = bus.dap_in_tvalid && bus.dap_in_tready;
  // Bits still owed after the one finishing now, and how many of those
  // sit in the already-fetched byte (7 - bit_idx) and are skipped on abort.
  assign bits_left = remaining - 9'd1;
  assign skip_bits = {6'd0, ~bit_idx};

  swj_clk_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_clk_gen (
    .clk        (clk),
    .resetn     (resetn),
    .run        (run),
    .half_period(clk_div_q),
    .tick       (tick)
  );

  // All outputs are registered and updated on the edge that enters the
  // state they belong to. SWCLK stays high while a byte is fetched, so a
  // stalled stream only stretches the high phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state              <= IDLE;
      clk_div_q          <= '0;
      remaining          <= '0;
      shift              <= '0;
      bit_idx            <= '0;
      aborted            <= 1'b0;
      SWCLK_TCK_O        <= 1'b1;
      SWDIO_TMS_O        <= 1'b1;
      SWDIO_TMS_T        <= 1'b1;
      bus.done           <= 1'b0;
      bus.dap_in_tready  <= 1'b0;
      bus.ram_write_en   <= 1'b0;
      bus.ram_write_addr <= '0;
      bus.ram_write_data <= '0;
      bus.packet_len     <= '0;
    end else begin
      bus.done         <= 1'b0;
      bus.ram_write_en <= 1'b0;

      if (abort_hit && (state inside {GET_COUNT, GET_DATA, CLK_LOW, CLK_HIGH})) begin
        aborted <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state             <= GET_COUNT;
            clk_div_q         <= bus.clk_div;
            aborted           <= 1'b0;
            bus.dap_in_tready <= 1'b1;
            SWDIO_TMS_T       <= 1'b0;
          end
        end

        GET_COUNT: begin
          // A count byte of zero encodes 256 bits.
          if (handshake) begin
            remaining <= {(bus.dap_in_tdata == 8'h00), bus.dap_in_tdata};
            state     <= GET_DATA;
          end
        end

        GET_DATA: begin
          if (handshake) begin
            if (aborted || abort_hit) begin
              // Draining: discard the byte without clocking it out.
              if (remaining <= 9'd8) begin
                remaining          <= '0;
                state              <= RESP0;
                bus.dap_in_tready  <= 1'b0;
                bus.ram_write_en   <= 1'b1;
                bus.ram_write_addr <= 10'd0;
                bus.ram_write_data <= DAP_CMD_SWJ_SEQUENCE;
              end else begin
                remaining <= remaining - 9'd8;
              end
            end else begin
              shift             <= bus.dap_in_tdata;
              bit_idx           <= '0;
              state             <= CLK_LOW;
              bus.dap_in_tready <= 1'b0;
              SWCLK_TCK_O       <= 1'b0;
              SWDIO_TMS_O       <= bus.dap_in_tdata[0];
            end
          end
        end

        CLK_LOW: begin
          if (tick) begin
            state       <= CLK_HIGH;
            SWCLK_TCK_O <= 1'b1;
          end
        end

        CLK_HIGH: begin
          if (tick) begin
            remaining <= bits_left;
            shift     <= shift >> 1;
            bit_idx   <= bit_idx + 3'd1;
            if (remaining == 9'd1 || ((aborted || abort_hit) && bits_left <= skip_bits)) begin
              state              <= RESP0;
              remaining          <= '0;
              bus.ram_write_en   <= 1'b1;
              bus.ram_write_addr <= 10'd0;
              bus.ram_write_data <= DAP_CMD_SWJ_SEQUENCE;
            end else if (aborted || abort_hit) begin
              // Drop the unsent bits of this byte, keep fetching the rest.
              remaining         <= bits_left - skip_bits;
              state             <= GET_DATA;
              bus.dap_in_tready <= 1'b1;
            end else if (bit_idx == 3'd7) begin
              state             <= GET_DATA;
              bus.dap_in_tready <= 1'b1;
            end else begin
              state       <= CLK_LOW;
              SWCLK_TCK_O <= 1'b0;
              SWDIO_TMS_O <= shift[1];
            end
          end
        end

        RESP0: begin
          state              <= RESP1;
          bus.ram_write_en   <= 1'b1;
          bus.ram_write_addr <= 10'd1;
          bus.ram_write_data <= aborted ? DAP_ERROR : DAP_OK;
        end

        RESP1: begin
          state          <= DONE;
          bus.done       <= 1'b1;
          bus.packet_len <= SWJ_SEQ_RESP_LEN;
        end

        DONE: begin
          state       <= IDLE;
          SWDIO_TMS_T <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dap_swj_sequence.sv
// tb_dap_swj_sequence
// Scoreboard bench for dap_swj_sequence. Each command pushes its
// expected SWCLK rising edges (TMS value and spacing), RAM writes and
// done/packet_len into queues; a monitor pops and compares whenever the
// DUT shows an edge, a RAM write or done. A stream driver feeds payload
// bytes with optional tvalid gaps and counts accepted bytes.
// The abort scenario is built only with DAP_SWJ_SEQ_ABORT_EN.
module tb_dap_swj_sequence;
  import dap_swj_sequence_pkg::*;

  localparam int DIV_WIDTH = 16;

  typedef struct {
    logic bit_val;
    bit   check_gap;
    int   gap;
  } edge_exp_t;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
  } ram_exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic swclk;
  logic tms;
  logic tms_t;
`ifdef DAP_SWJ_SEQ_ABORT_EN
  logic abort = 1'b0;
`endif

  dap_swj_sequence_if #(.DIV_WIDTH(DIV_WIDTH)) bus ();

  dap_swj_sequence #(
    .DIV_WIDTH(DIV_WIDTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .SWCLK_TCK_O(swclk),
    .SWDIO_TMS_O(tms),
    .SWDIO_TMS_T(tms_t)
`ifdef DAP_SWJ_SEQ_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int rise_count = 0;
  int rise_base = 0;
  int last_rise = 0;
  int done_seen = 0;
  int consumed = 0;
  bit mon_en = 1'b0;
  logic prev_swclk = 1'b1;

  edge_exp_t  exp_edges[$];
  ram_exp_t   exp_ram[$];
  int         exp_done[$];
  logic [7:0] feed_q[$];
  int         stall_q[$];
  logic [7:0] stim_data[$];
  int         stim_stall[$];
  int         exp_consumed;
  int         exp_left;
  logic       exp_last_bit;
  int         exp_limit;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %s, expected none", name, what);
  endtask

  // Payload stream source; a byte's gap only counts down while the DUT asks.
  initial begin
    bus.dap_in_tvalid = 1'b0;
    bus.dap_in_tdata  = 8'h00;
    forever begin
      @(negedge clk);
      if (feed_q.size() > 0) begin
        if (stall_q[0] > 0) begin
          bus.dap_in_tvalid = 1'b0;
          if (bus.dap_in_tready) stall_q[0] = stall_q[0] - 1;
        end else begin
          bus.dap_in_tvalid = 1'b1;
          bus.dap_in_tdata  = feed_q[0];
          if (bus.dap_in_tready) begin
            void'(feed_q.pop_front());
            void'(stall_q.pop_front());
            consumed++;
          end
        end
      end else begin
        bus.dap_in_tvalid = 1'b0;
      end
    end
  end

  // Output monitor / scoreboard.
  initial begin
    edge_exp_t e;
    ram_exp_t  r;
    int        len;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!prev_swclk && swclk) begin
          rise_count++;
          if (exp_edges.size() == 0) begin
            reportUnexpected("swclk_edge", "extra rising edge");
          end else begin
            e = exp_edges.pop_front();
            checkOutput("tms_bit", {31'd0, tms}, {31'd0, e.bit_val});
            checkOutput("tms_t_driven", {31'd0, tms_t}, 32'd0);
            if (e.check_gap) checkOutput("bit_period", cycle - last_rise, e.gap);
          end
          last_rise = cycle;
        end
        if (bus.dap_in_tready) checkOutput("swclk_high_fetch", {31'd0, swclk}, 32'd1);
        if (bus.ram_write_en) begin
          if (exp_ram.size() == 0) begin
            reportUnexpected("ram_write", "extra write");
          end else begin
            r = exp_ram.pop_front();
            checkOutput("ram_addr", {22'd0, bus.ram_write_addr}, {22'd0, r.addr});
            checkOutput("ram_data", {24'd0, bus.ram_write_data}, {24'd0, r.data});
          end
        end
        if (bus.done) begin
          done_seen++;
          if (exp_done.size() == 0) begin
            reportUnexpected("done", "unexpected done pulse");
          end else begin
            len = exp_done.pop_front();
            checkOutput("packet_len", {22'd0, bus.packet_len}, len);
          end
        end
      end
      prev_swclk = swclk;
    end
  end

  // Reference model: bit i of the sequence is bit (i mod 8) of payload
  // byte i/8; one count byte plus ceil(n/8) payload bytes are consumed.
  task automatic launchCommand(input int n, input int div, input int count_stall,
                               input int extra, input logic [7:0] status,
                               input int edges_to_expect);
    int         n_eff;
    int         nbytes;
    int         n_edges;
    logic [7:0] b;
    logic [7:0] cnt;
    edge_exp_t  e;
    n_eff   = (n == 0) ? 256 : n;
    nbytes  = (n_eff + 7) / 8;
    n_edges = (edges_to_expect < 0) ? n_eff : edges_to_expect;
    cnt     = n[7:0];
    feed_q.push_back(cnt);
    stall_q.push_back(count_stall);
    for (int i = 0; i < nbytes; i++) begin
      feed_q.push_back(stim_data[i]);
      stall_q.push_back(stim_stall[i]);
    end
    for (int i = 0; i < extra; i++) begin
      feed_q.push_back(8'($urandom));
      stall_q.push_back(0);
    end
    for (int i = 0; i < n_edges; i++) begin
      b = stim_data[i / 8];
      e.bit_val   = b[i % 8];
      e.check_gap = (i % 8) != 0;
      e.gap       = 2 * (div + 1);
      exp_edges.push_back(e);
      exp_last_bit = e.bit_val;
    end
    exp_ram.push_back('{addr: 10'd0, data: DAP_CMD_SWJ_SEQUENCE});
    exp_ram.push_back('{addr: 10'd1, data: status});
    exp_done.push_back(2);
    exp_consumed = 1 + nbytes;
    exp_left     = extra;
    exp_limit    = (n_eff + 4) * (2 * (div + 1) + 1) + count_stall + 100;
    for (int i = 0; i < nbytes; i++) exp_limit += stim_stall[i];
    consumed  = 0;
    rise_base = rise_count;
    @(negedge clk);
    bus.clk_div = DIV_WIDTH'(div);
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic finishCommand(input string tag);
    int done_before;
    done_before = done_seen - ((exp_done.size() == 0) ? 1 : 0);
    for (int k = 0; k < exp_limit && exp_done.size() != 0; k++) @(negedge clk);
    if (exp_done.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s done_timeout: got no done in %0d cycles, expected one", tag, exp_limit);
      exp_done.delete();
    end
    repeat (4) @(negedge clk);
    checkOutput({tag, " done_count"}, done_seen - done_before, 1);
    checkOutput({tag, " bytes_consumed"}, consumed, exp_consumed);
    checkOutput({tag, " bytes_left"}, feed_q.size(), exp_left);
    checkOutput({tag, " edges_missing"}, exp_edges.size(), 0);
    checkOutput({tag, " ram_missing"}, exp_ram.size(), 0);
    checkOutput({tag, " tms_hold"}, {31'd0, tms}, {31'd0, exp_last_bit});
    checkOutput({tag, " tms_t_idle"}, {31'd0, tms_t}, 32'd1);
    checkOutput({tag, " swclk_idle"}, {31'd0, swclk}, 32'd1);
    feed_q.delete();
    stall_q.delete();
    exp_edges.delete();
    exp_ram.delete();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input string tag, input int n, input int div,
                               input int count_stall, input int extra);
    launchCommand(n, div, count_stall, extra, DAP_OK, -1);
    finishCommand(tag);
  endtask

  task automatic fillRandom(input int n);
    int nbytes;
    nbytes = ((n == 0 ? 256 : n) + 7) / 8;
    stim_data.delete();
    stim_stall.delete();
    for (int i = 0; i < nbytes; i++) begin
      stim_data.push_back(8'($urandom));
      stim_stall.push_back($urandom_range(0, 2));
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " swclk"}, {31'd0, swclk}, 32'd1);
    checkOutput({tag, " tms"}, {31'd0, tms}, 32'd1);
    checkOutput({tag, " tms_t"}, {31'd0, tms_t}, 32'd1);
    checkOutput({tag, " done"}, {31'd0, bus.done}, 32'd0);
    checkOutput({tag, " ram_en"}, {31'd0, bus.ram_write_en}, 32'd0);
    checkOutput({tag, " tready"}, {31'd0, bus.dap_in_tready}, 32'd0);
    checkOutput({tag, " packet_len"}, {22'd0, bus.packet_len}, 32'd0);
    checkOutput({tag, " ram_addr"}, {22'd0, bus.ram_write_addr}, 32'd0);
    checkOutput({tag, " ram_data"}, {24'd0, bus.ram_write_data}, 32'd0);
  endtask

  initial begin
    int n;
    bus.start   = 1'b0;
    bus.clk_div = '0;
    #2 resetn = 1'b0;
    #1 checkResetValues("reset");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // 8 bits of 0xA5 at the fastest clock.
    stim_data  = {8'hA5};
    stim_stall = {0};
    applyStimulus("a5", 8, 0, 0, 0);

    // Count byte 0 means 256 bits.
    stim_data.delete();
    stim_stall.delete();
    for (int i = 0; i < 32; i++) begin
      stim_data.push_back(8'hFF);
      stim_stall.push_back(0);
    end
    applyStimulus("count256", 0, 3, 0, 0);

    // Partial byte; the byte after it must stay in the stream.
    stim_data  = {8'h06};
    stim_stall = {0};
    applyStimulus("count3", 3, 1, 0, 1);

    // tvalid gap of 10 cycles before the second payload byte.
    stim_data  = {8'h3C, 8'hC9};
    stim_stall = {0, 10};
    applyStimulus("stall", 16, 1, 2, 0);

    // Reset during bit 4, then a clean command.
    fillRandom(16);
    launchCommand(16, 1, 0, 0, DAP_OK, -1);
    for (int k = 0; k < 200 && rise_count < rise_base + 4; k++) @(negedge clk);
    checkOutput("reset_mid reached_bit4", rise_count - rise_base, 4);
    #2;
    mon_en = 1'b0;
    resetn = 1'b0;
    #1 checkResetValues("reset_mid");
    exp_edges.delete();
    exp_ram.delete();
    exp_done.delete();
    feed_q.delete();
    stall_q.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    fillRandom(12);
    applyStimulus("after_reset", 12, 2, 1, 0);

    // Randomised commands.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 40);
      fillRandom(n);
      applyStimulus("random", n, $urandom_range(0, 3), $urandom_range(0, 2), 0);
    end

`ifdef DAP_SWJ_SEQ_ABORT_EN
    // Abort during bit 2 of 16: both bytes drained, error status.
    fillRandom(16);
    launchCommand(16, 3, 0, 0, DAP_ERROR, 2);
    for (int k = 0; k < 200 && rise_count < rise_base + 2; k++) @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    finishCommand("abort");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
